stream_to_bus_deser: RTL and testbench

//   Collects K sequential SIZE-bit words from a valid/ready stream and packs them

---
 rtl/stream_to_bus_deser_pkg.sv | 15 +
 rtl/mod_k_counter.sv | 27 ++
 rtl/stream_to_bus_deser.sv | 88 ++++++++
 tb/tb_stream_to_bus_deser.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/stream_to_bus_deser_pkg.sv
// Shared types for the stream-to-bus deserializer.
// Holds the FSM state encoding and the slot-index width rule.
package stream_to_bus_deser_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } deser_state_t;

    // Matches the Mux_k_to_1 select width so slot can drive its sel directly
    function automatic int unsigned slot_bits(input int unsigned k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/mod_k_counter.sv
// Modulo-K slot counter: counts 0..K-1 and wraps explicitly from K-1 to 0.
// wrap is high while the count sits on its last value.
module mod_k_counter
    import stream_to_bus_deser_pkg::*;
#(
    parameter  int unsigned K   = 4,
    localparam int unsigned BIT = slot_bits(K)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           inc,
    output logic [BIT-1:0] count,
    output logic           wrap
);

    assign wrap = (count == BIT'(K - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + BIT'(1);
        end
    end

endmodule

// File: rtl/stream_to_bus_deser.sv
// Packs K sequential SIZE-bit stream words into one flat K*SIZE bus.
// Segment i of out_bus holds the i-th word received in the frame.
module stream_to_bus_deser
    import stream_to_bus_deser_pkg::*;
#(
    parameter  int unsigned K    = 4,
    parameter  int unsigned SIZE = 16,
    localparam int unsigned BIT  = slot_bits(K)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [SIZE-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [K*SIZE-1:0] out_bus,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BIT-1:0]    slot
);

    deser_state_t state;
    logic         acc;
    logic         drn;
    logic         wrap;
    logic         cnt_inc;
    int unsigned  base;

    assign in_ready = (state == FILL) || out_ready;
    assign acc      = in_valid && in_ready;
    assign drn      = out_valid && out_ready;
    // clear discards the word presented alongside it, so it must not advance slot
    assign cnt_inc  = acc && !clear;

    always_comb begin
        base = int'(slot) * SIZE;
    end

    mod_k_counter #(.K(K)) u_slot (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (cnt_inc),
        .count (slot),
        .wrap  (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            out_valid <= 1'b0;
            out_bus   <= '0;
        end else if (clear) begin
            state     <= FILL;
            out_valid <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (acc) begin
                        out_bus[base +: SIZE] <= in_data;
                        if (wrap) begin
                            state     <= FULL;
                            out_valid <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    // Accept in FULL implies drain; the word opens the next frame
                    if (drn) begin
                        if (acc) begin
                            out_bus[base +: SIZE] <= in_data;
                            state     <= wrap ? FULL : FILL;
                            out_valid <= wrap;
                        end else begin
                            state     <= FILL;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= FILL;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_to_bus_deser.sv
// Directed table plus hand-written sequences for stream_to_bus_deser (K=4, SIZE=16).
// Ends with a random-gap scoreboard run over 1000 words.
module tb_stream_to_bus_deser;

    localparam int unsigned K    = 4;
    localparam int unsigned SIZE = 16;
    localparam int unsigned NV   = 27;

    logic          clk;
    logic          rst;
    logic          clear;
    logic [15:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   out_bus;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    slot;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        rst;
        logic        clear;
        logic        in_valid;
        logic        out_ready;
        logic [15:0] data;
        logic        exp_ir;
        logic        exp_ov;
        logic [1:0]  exp_slot;
        logic [63:0] exp_bus;
    } vec_t;

    vec_t vecs [NV];

    stream_to_bus_deser #(.K(K), .SIZE(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bus   (out_bus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .slot      (slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] seg(input logic [63:0] b, input int i);
        return b[i*16 +: 16];
    endfunction

    initial begin
        //            rst   clr   iv    or    data      ir    ov    slot   bus
        // reset and first frame
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 2'd0, 64'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'hDDDD, 1'b1, 1'b0, 2'd1, 64'h0000_0000_0000_DDDD};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'hCCCC, 1'b1, 1'b0, 2'd2, 64'h0000_0000_CCCC_DDDD};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'hBBBB, 1'b1, 1'b0, 2'd3, 64'h0000_BBBB_CCCC_DDDD};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'hAAAA, 1'b1, 1'b1, 2'd0, 64'hAAAA_BBBB_CCCC_DDDD};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 2'd0, 64'hAAAA_BBBB_CCCC_DDDD};
        // backpressure
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 2'd1, 64'hAAAA_BBBB_CCCC_0001};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 2'd2, 64'hAAAA_BBBB_0002_0001};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b1, 1'b0, 2'd3, 64'hAAAA_0003_0002_0001};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0004, 1'b1, 1'b1, 2'd0, 64'h0004_0003_0002_0001};
        for (int i = 10; i < 15; i++)
            vecs[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h9999, 1'b0, 1'b1, 2'd0, 64'h0004_0003_0002_0001};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b1, 1'b0, 2'd1, 64'h0004_0003_0002_1111};
        // clear mid-frame, then clear on a frame about to drain
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h2222, 1'b1, 1'b0, 2'd2, 64'h0004_0003_2222_1111};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'hEEEE, 1'b1, 1'b0, 2'd0, 64'h0004_0003_2222_1111};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h5555, 1'b1, 1'b0, 2'd1, 64'h0004_0003_2222_5555};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h6666, 1'b1, 1'b0, 2'd2, 64'h0004_0003_6666_5555};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h7777, 1'b1, 1'b0, 2'd3, 64'h0004_7777_6666_5555};
        vecs[21] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h8888, 1'b1, 1'b1, 2'd0, 64'h8888_7777_6666_5555};
        vecs[22] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 2'd0, 64'h8888_7777_6666_5555};
        // reset mid-frame
        vecs[23] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0A0A, 1'b1, 1'b0, 2'd1, 64'h8888_7777_6666_0A0A};
        vecs[24] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0B0B, 1'b1, 1'b0, 2'd2, 64'h8888_7777_0B0B_0A0A};
        vecs[25] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0C0C, 1'b1, 1'b0, 2'd3, 64'h8888_0C0C_0B0B_0A0A};
        vecs[26] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 2'd0, 64'h0};

        rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

        for (int i = 0; i < int'(NV); i++) begin
            rst       = vecs[i].rst;
            clear     = vecs[i].clear;
            in_valid  = vecs[i].in_valid;
            out_ready = vecs[i].out_ready;
            in_data   = vecs[i].data;
            #1;
            if (i > 0) check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_ir));
            @(posedge clk); #1;
            check($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
            check($sformatf("v%0d_slot", i), 64'(slot), 64'(vecs[i].exp_slot));
            check($sformatf("v%0d_out_bus", i), out_bus, vecs[i].exp_bus);
            if (i == 4) begin
                check("sel0", 64'(seg(out_bus, 0)), 64'h DDDD);
                check("sel1", 64'(seg(out_bus, 1)), 64'h CCCC);
                check("sel2", 64'(seg(out_bus, 2)), 64'h BBBB);
                check("sel3", 64'(seg(out_bus, 3)), 64'h AAAA);
            end
        end
        rst = 1'b0;

        // eight words back-to-back: two frames, no bubble
        begin
            int ovcnt = 0;
            logic [63:0] expf [2];
            expf[0] = 64'h1003_1002_1001_1000;
            expf[1] = 64'h1007_1006_1005_1004;
            for (int j = 0; j < 9; j++) begin
                in_valid  = (j < 8);
                in_data   = 16'h1000 + 16'(j);
                out_ready = 1'b1;
                #1;
                check($sformatf("b2b%0d_in_ready", j), 64'(in_ready), 64'h1);
                @(posedge clk); #1;
                if (out_valid) begin
                    if (ovcnt < 2) check($sformatf("b2b_frame%0d", ovcnt), out_bus, expf[ovcnt]);
                    ovcnt++;
                end
            end
            in_valid = 1'b0;
            check("b2b_out_valid_cycles", 64'(ovcnt), 64'd2);
        end

        // random gaps over 1000 words with a scoreboard
        begin
            logic [15:0] q [$];
            int accepted = 0;
            int frames   = 0;
            int cyc      = 0;
            logic [63:0] exp;
            rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            while ((accepted < 1000 || out_valid) && cyc < 20000) begin
                in_valid  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
                in_data   = 16'(accepted * 7 + 3);
                out_ready = ($urandom_range(0, 2) != 0);
                #1;
                if (out_valid && out_ready) begin
                    exp = '0;
                    if (q.size() >= 4) begin
                        for (int s = 0; s < 4; s++) exp[s*16 +: 16] = q.pop_front();
                    end
                    check($sformatf("rand_frame%0d", frames), out_bus, exp);
                    frames++;
                end
                if (in_valid && in_ready) begin
                    q.push_back(in_data);
                    accepted++;
                end
                @(posedge clk); #1;
                cyc++;
            end
            in_valid = 1'b0; out_ready = 1'b0;
            check("rand_no_timeout", 64'(cyc < 20000), 64'h1);
            check("rand_frames", 64'(frames), 64'd250);
            check("rand_leftover", 64'(q.size()), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
